vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: pipelined video fetches with absolute priority, CPU four-phase handshake.
// Optional one-entry posted write buffer when VRAM_POSTED_WRITE_EN is defined. System constraint: keep vid_req duty <= 1/2.
//
// state | meaning
// IDLE  | no CPU access, waiting for cpu_req
// PEND  | access captured, waiting for a free RAM slot
// RDATA | read issued last cycle, RAM data arriving
// ACK   | cpu_ack high until cpu_req drops
module vram_arbiter #(
    parameter int AW = 14
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic [7:0]    vid_do,
    output logic          vid_valid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_a,
    input  logic [7:0]    cpu_di,
    output logic [7:0]    cpu_do,
    output logic          cpu_ack,
    output logic          wait_n,
    output logic [AW-1:0] mem_a,
    output logic          mem_we_n,
    output logic [7:0]    mem_di,
    input  logic [7:0]    mem_do
);

    typedef enum logic [1:0] {IDLE, PEND, RDATA, ACK} cpu_state_e;

    cpu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    cpu_do_q, cpu_do_d;
    logic          vid_valid_q;
    logic [7:0]    vid_hold_q;
    logic          cpu_issue;

`ifdef VRAM_POSTED_WRITE_EN
    logic          wb_full_q, wb_full_d;
    logic [AW-1:0] wb_a_q, wb_a_d;
    logic [7:0]    wb_d_q, wb_d_d;
    logic          wb_drain;
`endif

    // RAM port mux; gated by reset so an aborted or buffered write never reaches RAM
    always_comb begin
        mem_a     = '0;
        mem_we_n  = 1'b1;
        mem_di    = '0;
        cpu_issue = 1'b0;
`ifdef VRAM_POSTED_WRITE_EN
        wb_drain  = 1'b0;
`endif
        if (reset) begin
            if (vid_req) begin
                mem_a = vid_a;
            end
`ifdef VRAM_POSTED_WRITE_EN
            else if (wb_full_q) begin
                mem_a    = wb_a_q;
                mem_we_n = 1'b0;
                mem_di   = wb_d_q;
                wb_drain = 1'b1;
            end
`endif
            else if (state_q == PEND) begin
                cpu_issue = 1'b1;
                mem_a     = addr_q;
                if (we_q) begin
                    mem_we_n = 1'b0;
                    mem_di   = data_q;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cpu_do_d = cpu_do_q;
`ifdef VRAM_POSTED_WRITE_EN
        wb_full_d = wb_full_q & ~wb_drain;
        wb_a_d    = wb_a_q;
        wb_d_d    = wb_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_a;
                    data_d  = cpu_di;
                    state_d = PEND;
`ifdef VRAM_POSTED_WRITE_EN
                    if (cpu_we && !wb_full_q) begin
                        wb_full_d = 1'b1;
                        wb_a_d    = cpu_a;
                        wb_d_d    = cpu_di;
                        state_d   = ACK;
                    end
`endif
                end
            end
            PEND: begin
                if (cpu_issue) state_d = we_q ? ACK : RDATA;
            end
            RDATA: begin
                cpu_do_d = mem_do;
                state_d  = ACK;
            end
            ACK: begin
                if (!cpu_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            cpu_do_q    <= '0;
            vid_valid_q <= 1'b0;
            vid_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            cpu_do_q    <= cpu_do_d;
            vid_valid_q <= vid_req;
            if (vid_valid_q) vid_hold_q <= mem_do;
        end
    end

`ifdef VRAM_POSTED_WRITE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_full_q <= 1'b0;
            wb_a_q    <= '0;
            wb_d_q    <= '0;
        end else begin
            wb_full_q <= wb_full_d;
            wb_a_q    <= wb_a_d;
            wb_d_q    <= wb_d_d;
        end
    end
`endif

    // RAM data arrives in the cycle after issue; pass it straight through then hold it
    assign vid_do    = vid_valid_q ? mem_do : vid_hold_q;
    assign vid_valid = vid_valid_q;
    assign cpu_do    = cpu_do_q;
    assign cpu_ack   = (state_q == ACK);
    assign wait_n    = !((state_q == PEND) || (state_q == RDATA));

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: random video traffic and CPU transactions against a transaction-level
// model of ack timing and RAM contents; follows VRAM_POSTED_WRITE_EN when defined.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int AW   = 14;
    localparam int NCYC = 6000;
`ifdef VRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          vid_req, cpu_req, cpu_we;
    logic [AW-1:0] vid_a, cpu_a;
    logic [7:0]    cpu_di;
    logic [7:0]    vid_do, cpu_do, mem_di, mem_do;
    logic          vid_valid, cpu_ack, wait_n, mem_we_n;
    logic [AW-1:0] mem_a;

    always #5 clock = ~clock;

    vram_arbiter #(.AW(AW)) dut (
        .clock(clock), .reset(reset),
        .vid_req(vid_req), .vid_a(vid_a), .vid_do(vid_do), .vid_valid(vid_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di),
        .cpu_do(cpu_do), .cpu_ack(cpu_ack), .wait_n(wait_n),
        .mem_a(mem_a), .mem_we_n(mem_we_n), .mem_di(mem_di), .mem_do(mem_do)
    );

    // synchronous single-port RAM seen by the arbiter
    logic [7:0] ram     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_we_n === 1'b0) ram[mem_a] <= mem_di;
        mem_do <= ram[mem_a];
    end

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [7:0]    d;
        logic [7:0]    old;
    } wr_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            vs [NCYC];
    wr_t           wq [$];
    int            buf_drain = -1;
    int            rd_issue = -1;
    logic [AW-1:0] ra;
    bit            vfix = 1'b0;
    logic [AW-1:0] vfa;
    int            last_lat;
    int            vv_count = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int first_low(input int from);
        int c = from;
        while (c < NCYC && vs[c]) c++;
        return c;
    endfunction

    task automatic set_vid(input int s, input int len, input bit val);
        for (int i = 0; i < len; i++) if (s + i < NCYC) vs[s + i] = val;
    endtask

    // run one cycle: drive video, check the RAM bus mid-cycle, check registered outputs after
    task automatic step();
        int            hit;
        logic          pv;
        logic [AW-1:0] pa;
        vid_req = vs[cyc];
        vid_a   = vfix ? vfa : AW'($urandom_range(0, 'h1FF));
        #1;
        hit = -1;
        foreach (wq[i]) if (wq[i].c == cyc) hit = i;
        if (vid_req) begin
            chk("vid_mem_a", mem_a, vid_a);
            chk("vid_we_n", mem_we_n, 1);
        end else if (hit >= 0) begin
            chk("wr_we_n", mem_we_n, 0);
            chk("wr_mem_a", mem_a, wq[hit].a);
            chk("wr_mem_di", mem_di, wq[hit].d);
            chk("ram_before_wr", ram[wq[hit].a], wq[hit].old);
        end else begin
            chk("idle_we_n", mem_we_n, 1);
            if (cyc == rd_issue) chk("rd_mem_a", mem_a, ra);
        end
        pv = vid_req;
        pa = vid_a;
        @(negedge clock);
        cyc++;
        chk("vid_valid", vid_valid, pv);
        if (vid_valid === 1'b1) vv_count++;
        if (pv) chk("vid_do", vid_do, ref_mem[pa]);
        if (hit >= 0) begin
            chk("ram_after_wr", ram[wq[hit].a], wq[hit].d);
            wq.delete(hit);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cpu_xact(input bit we, input logic [AW-1:0] a, input logic [7:0] d, input int hold);
        int         c0, ack, issue, first;
        logic [7:0] exp_do = '0;
        c0 = cyc;
        cpu_req = 1'b1; cpu_we = we; cpu_a = a; cpu_di = d;
        first = -1;
        if (POSTED && we && c0 > buf_drain) begin
            ack       = c0 + 1;
            buf_drain = first_low(c0 + 1);
            wq.push_back('{buf_drain, a, d, ref_mem[a]});
            ref_mem[a] = d;
        end else begin
            issue = first_low((buf_drain + 1 > c0 + 1) ? buf_drain + 1 : c0 + 1);
            if (we) begin
                ack = issue + 1;
                wq.push_back('{issue, a, d, ref_mem[a]});
                ref_mem[a] = d;
            end else begin
                ack      = issue + 2;
                rd_issue = issue;
                ra       = a;
                exp_do   = ref_mem[a];
            end
        end
        while (cyc < ack + hold) begin
            chk("wait_n", wait_n, !(cyc > c0 && cyc < ack));
            chk("cpu_ack", cpu_ack, cyc >= ack);
            if (cpu_ack === 1'b1 && first < 0) first = cyc - c0;
            step();
        end
        chk("ack_held", cpu_ack, 1);
        if (first < 0) first = cyc - c0;
        last_lat = first;
        if (!we) chk("cpu_do", cpu_do, exp_do);
        cpu_req = 1'b0;
        step();
        chk("ack_release", cpu_ack, 0);
        chk("wait_n_release", wait_n, 1);
        rd_issue = -1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_vid_valid"}, vid_valid, 0);
        chk({tag, "_cpu_ack"}, cpu_ack, 0);
        chk({tag, "_wait_n"}, wait_n, 1);
        chk({tag, "_mem_we_n"}, mem_we_n, 1);
        chk({tag, "_mem_a"}, mem_a, 0);
        chk({tag, "_mem_di"}, mem_di, 0);
        chk({tag, "_vid_do"}, vid_do, 0);
        chk({tag, "_cpu_do"}, cpu_do, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] old1, old2;
        int         c, v0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_di = '0;
        vid_req = 1'b0; vid_a = '0; vfa = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        for (int i = 0; i < NCYC; i++) vs[i] = ($urandom_range(0, 2) == 0);
        ram['h0010] = 8'h5A; ref_mem['h0010] = 8'h5A;
        ram['h1234] = 8'hC3; ref_mem['h1234] = 8'hC3;

        // reset held with active inputs: outputs must stay at reset values
        vid_req = 1'b1; vid_a = 'h123; cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 'h2222; cpu_di = 8'h77;
        repeat (3) @(negedge clock);
        chk_reset_outputs("rst");
        vid_req = 1'b0; cpu_req = 1'b0;
        reset = 1'b1;

        // single video fetch
        set_vid(cyc, 12, 1'b0);
        vs[cyc + 2] = 1'b1;
        vfix = 1'b1; vfa = 'h0010;
        step(); step(); step();
        chk("vid_fetch_valid", vid_valid, 1);
        chk("vid_fetch_data", vid_do, 8'h5A);
        vfix = 1'b0;
        idle(2);

        // uncontended read
        set_vid(cyc, 12, 1'b0);
        cpu_xact(1'b0, 'h1234, 8'h00, 0);
        chk("rd_latency", last_lat, 3);
        chk("rd_data", cpu_do, 8'hC3);

        // read held off by four video cycles
        c = cyc;
        set_vid(c, 14, 1'b0);
        set_vid(c + 1, 4, 1'b1);
        v0 = vv_count;
        cpu_xact(1'b0, 'h0777, 8'h00, 0);
        chk("contended_rd_latency", last_lat, 7);
        chk("vid_pulses_during_wait", vv_count - v0, 4);

        // write then read back
        set_vid(cyc, 16, 1'b0);
        cpu_xact(1'b1, 'h0200, 8'hA5, 0);
        chk("wr_latency", last_lat, POSTED ? 1 : 2);
        cpu_xact(1'b0, 'h0200, 8'h00, 1);
        chk("wr_rd_back", cpu_do, 8'hA5);

        // write under continuous video
        c = cyc;
        set_vid(c, 20, 1'b0);
        set_vid(c, 6, 1'b1);
        old1 = ref_mem['h2345];
        cpu_xact(1'b1, 'h2345, 8'h96, 0);
        chk("wr_contend_latency", last_lat, POSTED ? 1 : 7);
        chk("ram_during_vid", ram['h2345], POSTED ? old1 : 8'h96);
        idle(6);
        chk("ram_after_vid", ram['h2345], 8'h96);

        // randomized traffic
        for (int n = 0; n < 120; n++) begin
            bit            we;
            logic [AW-1:0] a;
            we = 1'($urandom_range(0, 1));
            a  = we ? AW'('h2000 + $urandom_range(0, 'h1FFF)) : AW'($urandom);
            cpu_xact(we, a, 8'($urandom), $urandom_range(0, 2));
            idle($urandom_range(0, 3));
        end
        set_vid(cyc, 10, 1'b0);
        idle(4);

        // reset during PEND (with a buffered write in the posted build)
        set_vid(cyc, 30, 1'b1);
        old1 = ref_mem['h2ABC];
        old2 = ref_mem['h2DEF];
        if (POSTED) cpu_xact(1'b1, 'h2ABC, 8'h11, 0);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 'h2DEF; cpu_di = 8'h22;
        step(); step();
        chk("pend_wait_n", wait_n, 0);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        repeat (2) begin
            @(negedge clock);
            cyc++;
        end
        chk_reset_outputs("midrst_hold");
        wq.delete();
        buf_drain = -1;
        rd_issue  = -1;
        ref_mem['h2ABC] = old1;
        ref_mem['h2DEF] = old2;
        cpu_req = 1'b0; vid_req = 1'b0;
        reset = 1'b1;
        set_vid(cyc, 12, 1'b0);
        idle(6);
        chk("ram_abort_buffered", ram['h2ABC], old1);
        chk("ram_abort_pend", ram['h2DEF], old2);
        cpu_xact(1'b0, 'h2ABC, 8'h00, 0);
        chk("post_rst_rd_latency", last_lat, 3);
        chk("post_rst_rd_data", cpu_do, old1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
